// File: rtl/dma_rq_read_if.sv
// dma_rq_read_if: command, RQ AXI-Stream and tag-tracking signals of the DMA read requester
interface dma_rq_read_if #(
    parameter int C_BUS_DATA_WIDTH = 256,
    parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 32,
    parameter int C_WINDOW_SIZE    = 16
);
    logic                          CMD_VALID;
    logic                          CMD_READY;
    logic [63:0]                   CMD_ADDR;
    logic [31:0]                   CMD_BYTES;
    logic [63:0]                   CURRENT_WINDOW_SIZE;
    logic [C_BUS_DATA_WIDTH-1:0]   M_AXIS_RQ_TDATA;
    logic [59:0]                   M_AXIS_RQ_TUSER;
    logic [C_BUS_KEEP_WIDTH-1:0]   M_AXIS_RQ_TKEEP;
    logic                          M_AXIS_RQ_TLAST;
    logic                          M_AXIS_RQ_TVALID;
    logic                          M_AXIS_RQ_TREADY;
    logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS;
    logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS;
    logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS;
    logic [63:0]                   BYTE_COUNT;
    logic                          DONE;

    modport master (
        input  CMD_VALID, CMD_ADDR, CMD_BYTES, CURRENT_WINDOW_SIZE, M_AXIS_RQ_TREADY, COMPLETED_TAGS,
        output CMD_READY, M_AXIS_RQ_TDATA, M_AXIS_RQ_TUSER, M_AXIS_RQ_TKEEP, M_AXIS_RQ_TLAST,
               M_AXIS_RQ_TVALID, BUSY_TAGS, SIZE_TAGS, BYTE_COUNT, DONE
    );

    modport slave (
        output CMD_VALID, CMD_ADDR, CMD_BYTES, CURRENT_WINDOW_SIZE, M_AXIS_RQ_TREADY, COMPLETED_TAGS,
        input  CMD_READY, M_AXIS_RQ_TDATA, M_AXIS_RQ_TUSER, M_AXIS_RQ_TKEEP, M_AXIS_RQ_TLAST,
               M_AXIS_RQ_TVALID, BUSY_TAGS, SIZE_TAGS, BYTE_COUNT, DONE
    );
endinterface

// File: rtl/dma_rq_read_logic.sv
// dma_rq_read_logic: splits host-read commands into tagged memory-read TLPs; optional DMA_RQ_4K_BOUNDARY_EN splits at 4 KB boundaries
module dma_rq_read_logic #(
    parameter int C_BUS_DATA_WIDTH        = 256,
    parameter int C_BUS_KEEP_WIDTH        = C_BUS_DATA_WIDTH / 32,
    parameter int C_WINDOW_SIZE           = 16,
    parameter int C_LOG2_MAX_READ_REQUEST = 9
) (
    input logic            CLK,
    input logic            RST_N,
    dma_rq_read_if.master  bus
);
    localparam int TW = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
    localparam logic [31:0] MAX_RR = 32'(1) << C_LOG2_MAX_READ_REQUEST;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]               state;
    logic [63:0]              addr_r;
    logic [31:0]              rem_r;
    logic [31:0]              chunk_r;
    logic [31:0]              chunk_w;
    logic [TW-1:0]            tag_r;
    logic [TW-1:0]            tag_w;
    logic                     tag_ok;
    logic [63:0]              win_w;
    logic [C_WINDOW_SIZE-1:0] busy_r;
    logic [C_WINDOW_SIZE-1:0] set_w;
    logic [10:0]              size_r [C_WINDOW_SIZE];
    logic [63:0]              byte_cnt_r;
    logic                     done_r;
    logic [10:0]              dw;
    logic                     hs_tlp;

    assign dw     = chunk_r[12:2];
    assign hs_tlp = (state == SEND) && bus.M_AXIS_RQ_TREADY;
    assign set_w  = hs_tlp ? ({{(C_WINDOW_SIZE-1){1'b0}}, 1'b1} << tag_r) : '0;

    // effective window: 0 or oversize means the full tag range
    always_comb begin
        win_w = (bus.CURRENT_WINDOW_SIZE == 64'd0 || bus.CURRENT_WINDOW_SIZE > 64'(C_WINDOW_SIZE))
              ? 64'(C_WINDOW_SIZE) : bus.CURRENT_WINDOW_SIZE;
    end

    // lowest free tag inside the effective window
    always_comb begin
        tag_ok = 1'b0;
        tag_w  = '0;
        for (int j = C_WINDOW_SIZE - 1; j >= 0; j--) begin
            if (!busy_r[j] && 64'(j) < win_w) begin
                tag_ok = 1'b1;
                tag_w  = TW'(j);
            end
        end
    end

`ifdef DMA_RQ_4K_BOUNDARY_EN
    logic [31:0] lim_w;
    assign lim_w = 32'h1000 - {20'd0, addr_r[11:0]};
    // chunk bounded by remaining bytes, max read request and the next 4 KB boundary
    always_comb begin
        chunk_w = (rem_r < MAX_RR) ? rem_r : MAX_RR;
        chunk_w = (chunk_w < lim_w) ? chunk_w : lim_w;
    end
`else
    // chunk bounded by remaining bytes and max read request
    always_comb begin
        chunk_w = (rem_r < MAX_RR) ? rem_r : MAX_RR;
    end
`endif

    // command sequencing: accept, size/tag each TLP, issue, then wait for all tags to retire
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            addr_r     <= '0;
            rem_r      <= '0;
            chunk_r    <= '0;
            tag_r      <= '0;
            byte_cnt_r <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.CMD_VALID) begin
                    addr_r     <= bus.CMD_ADDR & ~64'h3;
                    rem_r      <= bus.CMD_BYTES & ~32'h3;
                    byte_cnt_r <= '0;
                    state      <= ((bus.CMD_BYTES & ~32'h3) == 32'd0) ? DRAIN : CALC;
                end
                CALC: if (tag_ok) begin
                    tag_r   <= tag_w;
                    chunk_r <= chunk_w;
                    state   <= SEND;
                end
                SEND: if (bus.M_AXIS_RQ_TREADY) begin
                    addr_r     <= addr_r + 64'(chunk_r);
                    rem_r      <= rem_r - chunk_r;
                    byte_cnt_r <= byte_cnt_r + 64'(chunk_r);
                    state      <= (rem_r == chunk_r) ? DRAIN : CALC;
                end
                DRAIN: if (busy_r == '0) begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tag bookkeeping: set on TLP handshake, clear on completion; stray completions fall out of the AND
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r <= '0;
            for (int j = 0; j < C_WINDOW_SIZE; j++) size_r[j] <= '0;
        end else begin
            busy_r <= (busy_r & ~bus.COMPLETED_TAGS) | set_w;
            if (hs_tlp) size_r[tag_r] <= dw;
        end
    end

    // flatten per-tag sizes
    always_comb begin
        bus.SIZE_TAGS = '0;
        for (int j = 0; j < C_WINDOW_SIZE; j++) bus.SIZE_TAGS[11*j +: 11] = size_r[j];
    end

    // descriptor decoded purely from registered state, zero when idle
    always_comb begin
        bus.M_AXIS_RQ_TDATA = '0;
        bus.M_AXIS_RQ_TUSER = '0;
        if (state == SEND) begin
            bus.M_AXIS_RQ_TDATA[63:0]   = {addr_r[63:2], 2'b00};
            bus.M_AXIS_RQ_TDATA[74:64]  = dw;
            bus.M_AXIS_RQ_TDATA[103:96] = 8'(tag_r);
            bus.M_AXIS_RQ_TUSER[3:0]    = 4'hF;
            bus.M_AXIS_RQ_TUSER[7:4]    = (dw > 11'd1) ? 4'hF : 4'h0;
        end
    end

    assign bus.CMD_READY        = (state == IDLE);
    assign bus.M_AXIS_RQ_TVALID = (state == SEND);
    assign bus.M_AXIS_RQ_TLAST  = (state == SEND);
    assign bus.M_AXIS_RQ_TKEEP  = (state == SEND) ? {{(C_BUS_KEEP_WIDTH-4){1'b0}}, 4'hF} : '0;
    assign bus.BUSY_TAGS        = busy_r;
    assign bus.BYTE_COUNT       = byte_cnt_r;
    assign bus.DONE             = done_r;
endmodule

// File: doc/dma_rq_read_logic.md
# dma_rq_read_logic

Requester-request (RQ) transmitter for the DMA read path. It splits one host-read command into memory-read TLPs, assigns each TLP a tag from a bounded window, and publishes per-tag busy flags and expected DWORD counts. The completion receiver consumes those flags and counts, and returns COMPLETED_TAGS to free each tag. It sits between the DMA descriptor engine and the PCIe core's RQ AXI-Stream port.

## Interface
- C_BUS_DATA_WIDTH, 256: RQ bus width; only 256 is supported.
- C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/32: TKEEP width, one bit per DWORD.
- C_WINDOW_SIZE, 16: number of tags; tags are 0..C_WINDOW_SIZE-1.
- C_LOG2_MAX_READ_REQUEST, 9: maximum read request size is 2**value bytes; legal range 7..12.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when high together with CMD_VALID.
- CMD_ADDR  in  64  host byte address; bits [1:0] are ignored (treated as 0).
- CMD_BYTES  in  32  length in bytes; bits [1:0] are ignored.
- CURRENT_WINDOW_SIZE  in  64  maximum number of outstanding tags; 0 or values above C_WINDOW_SIZE mean C_WINDOW_SIZE.
- M_AXIS_RQ_TDATA  out  C_BUS_DATA_WIDTH  request descriptor.
- M_AXIS_RQ_TUSER  out  60  [3:0] first_be, [7:4] last_be, remaining bits 0.
- M_AXIS_RQ_TKEEP  out  C_BUS_KEEP_WIDTH  8'h0F while valid.
- M_AXIS_RQ_TLAST  out  1  1 while valid.
- M_AXIS_RQ_TVALID  out  1  TLP valid.
- M_AXIS_RQ_TREADY  in  1  core ready.
- BUSY_TAGS  out  C_WINDOW_SIZE  tag outstanding.
- SIZE_TAGS  out  C_WINDOW_SIZE*11  expected DWORDs of tag j, in bits [11j+10:11j].
- COMPLETED_TAGS  in  C_WINDOW_SIZE  one-cycle pulse per tag whose completions are all received.
- BYTE_COUNT  out  64  bytes issued so far for the current command.
- DONE  out  1  one-cycle pulse when a command is fully completed.

## Operation
- FSM states: IDLE, CALC, SEND, DRAIN.
- **IDLE**
  - CMD_READY=1.
  - On handshake: latch addr_r, rem_r = CMD_BYTES & ~3, clear BYTE_COUNT.
  - If rem_r=0, go to DRAIN; otherwise go to CALC.
- **CALC**
  - chunk = min(rem_r, 2**C_LOG2_MAX_READ_REQUEST), further limited by the 4 KB rule (see Configuration).
  - Tag selection: lowest-index tag j with BUSY_TAGS[j]=0 and j < effective window.
  - If a tag exists: latch tag and chunk, go to SEND. Otherwise stay in CALC and re-evaluate every cycle.
- **SEND**
  - TVALID=1; all outputs are held stable until TREADY.
  - Descriptor fields:
    - TDATA[63:2] = addr_r[63:2], [1:0] = 0.
    - [74:64] = chunk/4 (1024 is encoded as 11'd1024).
    - [78:75] = 4'b0000 (memory read).
    - [103:96] = tag.
    - All other descriptor bits 0.
  - first_be = 4'hF; last_be = 4'hF if dwords > 1, else 4'h0.
  - On handshake:
    - Set BUSY_TAGS[tag] and SIZE_TAGS[tag] = dwords.
    - addr_r += chunk; rem_r -= chunk; BYTE_COUNT += chunk.
    - Go to DRAIN if rem_r becomes 0; otherwise go to CALC.
- **DRAIN**
  - Wait until BUSY_TAGS == 0, then pulse DONE and go to IDLE.
- Tag release:
  - COMPLETED_TAGS[j] clears BUSY_TAGS[j] on the next edge. SIZE_TAGS[j] keeps its value until the tag is reused.
  - COMPLETED_TAGS on a tag that is not busy is ignored.
  - Set and clear of different tags in the same cycle both take effect. The same tag cannot be set and cleared together, because only free tags are issued.
- Reducing CURRENT_WINDOW_SIZE mid-command never revokes issued tags; it only restricts new allocations.
- Arithmetic: rem_r is 32 bits, addr_r is 64 bits. addr_r wraps modulo 2**64 without a flag.

## Timing
- Reset values: CMD_READY=1, TVALID=0, TDATA/TUSER/TKEEP/TLAST=0, BUSY_TAGS=0, SIZE_TAGS=0, BYTE_COUNT=0, DONE=0; FSM in IDLE.
- Outputs are registered.
- Latency:
  - Command handshake at edge N → CALC during N+1 → TVALID from N+2 if a tag is free.
  - Sustained rate is one TLP per 2 cycles with TREADY=1.
- TVALID never drops without a handshake.
- Reset asserted mid-command aborts immediately. All outstanding tags are forgotten and late completions are ignored.
- DONE asserts the cycle after BUSY_TAGS is seen as 0 in DRAIN. A zero-length command pulses DONE 2 cycles after its handshake.

## Configuration
- DMA_RQ_4K_BOUNDARY_EN
  - Defined: chunk is additionally limited to 4096 - addr_r[11:0], so no TLP crosses a 4 KB boundary.
  - Undefined: no boundary split; the caller guarantees that commands never cross a 4 KB boundary.

## Test plan
- Addr 0x1000, bytes 512, max read request 2**9, TREADY=1 → one TLP: dwords 128, tag 0, first_be F, last_be F; BUSY_TAGS=0x0001; SIZE_TAGS[0]=128; COMPLETED_TAGS[0] → DONE.
- Bytes 2048, window 2, no completions → tags 0 and 1 issued, then stall in CALC. Pulse COMPLETED_TAGS[0] → tag 0 reissued with addr +1024.
- With DMA_RQ_4K_BOUNDARY_EN: addr 0x0F80, bytes 256 → TLPs of 128 B at 0x0F80 and 128 B at 0x1000. Without the macro: one 256 B TLP.
- Bytes 4 → dwords 1, last_be 0; bytes 0 → no TLP, DONE pulse 2 cycles after the handshake.
- TREADY low for 5 cycles during SEND → TDATA/TVALID stable; BUSY_TAGS set only after the handshake.
- Reset asserted with 3 tags busy → BUSY_TAGS=0, TVALID=0, CMD_READY=1 immediately.
